// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, IF/ID pipeline register, fetch counter
// and a small BOOT/RUN sequencer whose state is visible for debug.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [5:0]  NOP_OPCODE = 6'b111111
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic [31:0] if_id_instr,
  output logic [31:0] if_id_pc4,
  output logic        if_id_valid,
  output logic [5:0]  opcode,
  output logic [31:0] fetch_count,
  output logic        booting
);

  typedef enum logic {BOOT, RUN} state_t;

  state_t      state, state_next;
  logic [31:0] pc_plus4;
  logic [31:0] pc_next;
  logic [31:0] instr_next;
  logic [31:0] pc4_next;
  logic        valid_next;
  logic [31:0] count_next;

  assign pc_plus4  = pc + 32'd4;  // wraps modulo 2^32
  assign imem_addr = pc;
  assign opcode    = if_id_valid ? if_id_instr[31:26] : NOP_OPCODE;
  assign booting   = (state == BOOT);

  // Sequencer: BOOT lasts exactly one cycle after reset, then RUN forever.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can leave
    // it unassigned and infer a latch.
    state_next = state;
    unique case (state)
      BOOT:    state_next = RUN;
      RUN:     state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Next-PC and IF/ID next values; a redirect outranks stall in both paths.
  always_comb begin
    pc_next    = pc_plus4;
    instr_next = imem_rdata;
    pc4_next   = pc_plus4;
    valid_next = 1'b1;
    count_next = fetch_count + 32'd1;

    if (branch_taken) begin
      pc_next = {branch_target[31:2], 2'b00};
    end else if (stall) begin
      pc_next = pc;
    end

    // BOOT loads exactly like RUN, so the first word is fetched without a
    // dead cycle.
    if (flush || branch_taken) begin
      instr_next = 32'd0;
      pc4_next   = 32'd0;
      valid_next = 1'b0;
      count_next = fetch_count;
    end else if (stall) begin
      instr_next = if_id_instr;
      pc4_next   = if_id_pc4;
      valid_next = if_id_valid;
      count_next = fetch_count;
    end
  end

  // State registers with synchronous active-low reset that overrides all controls.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    if (!rst_n) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      if_id_instr <= 32'd0;
      if_id_pc4   <= 32'd0;
      if_id_valid <= 1'b0;
      fetch_count <= 32'd0;
    end else begin
      state       <= state_next;
      pc          <= pc_next;
      if_id_instr <= instr_next;
      if_id_pc4   <= pc4_next;
      if_id_valid <= valid_next;
      fetch_count <= count_next;
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage: two instances (default reset PC and a
// reset PC at the top of the address space), a small instruction memory model
// and hand-computed expected values.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, branch_taken;
  logic [31:0] branch_target;
  logic [31:0] imem_addr, imem_rdata, pc, if_id_instr, if_id_pc4, fetch_count;
  logic        if_id_valid, booting;
  logic [5:0]  opcode;

  logic [31:0] imem_addr2, imem_rdata2, pc2, if_id_instr2, if_id_pc42, fetch_count2;
  logic        if_id_valid2, booting2;
  logic [5:0]  opcode2;
  logic        zero_bit = 1'b0;
  logic [31:0] zero_word = 32'd0;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  // Instruction memory contents used by the directed vectors.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    case (addr)
      32'h0000_0000: mem_word = 32'h8C02_0004;
      32'h0000_0004: mem_word = 32'hAC02_0008;
      32'h0000_0008: mem_word = 32'h2001_0001;
      32'h0000_0040: mem_word = 32'h3C01_1234;
      default:       mem_word = {6'b000010, addr[27:2]};
    endcase
  endfunction

  assign imem_rdata  = mem_word(imem_addr);
  assign imem_rdata2 = mem_word(imem_addr2);

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_addr(imem_addr), .imem_rdata(imem_rdata), .pc(pc),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4), .if_id_valid(if_id_valid),
    .opcode(opcode), .fetch_count(fetch_count), .booting(booting)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .stall(zero_bit), .flush(zero_bit),
    .branch_taken(zero_bit), .branch_target(zero_word),
    .imem_addr(imem_addr2), .imem_rdata(imem_rdata2), .pc(pc2),
    .if_id_instr(if_id_instr2), .if_id_pc4(if_id_pc42), .if_id_valid(if_id_valid2),
    .opcode(opcode2), .fetch_count(fetch_count2), .booting(booting2)
  );

  task automatic check(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, actual, expected);
    end
  endtask

  // One rising edge, then return at the falling edge where outputs are sampled.
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_slot(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_pc4, input logic e_valid, input logic [31:0] e_count);
    check({tag, ".pc"},    pc,          e_pc);
    check({tag, ".instr"}, if_id_instr, e_instr);
    check({tag, ".pc4"},   if_id_pc4,   e_pc4);
    check({tag, ".valid"}, {31'd0, if_id_valid}, {31'd0, e_valid});
    check({tag, ".count"}, fetch_count, e_count);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b1;
    branch_target = 32'h0000_0100;
    @(negedge clk);

    // Reset edge ignores the branch request.
    step();
    check_slot("reset", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("reset.opcode",  {26'd0, opcode}, {26'd0, 6'b111111});
    check("reset.booting", {31'd0, booting}, 32'd1);
    check("reset.imem_addr", imem_addr, 32'h0);
    check("wrap.reset_pc", pc2, 32'hFFFF_FFFC);

    // Reset release: first word captured with no dead cycle.
    rst_n = 1'b1; branch_taken = 1'b0;
    step();
    check_slot("cyc1", 32'h4, 32'h8C02_0004, 32'h4, 1'b1, 32'd1);
    check("cyc1.opcode",  {26'd0, opcode}, {26'd0, 6'b100011});
    check("cyc1.booting", {31'd0, booting}, 32'd0);
    check("wrap.cyc1.pc",  pc2, 32'h0);
    check("wrap.cyc1.pc4", if_id_pc42, 32'h0);

    step();
    check_slot("cyc2", 32'h8, 32'hAC02_0008, 32'h8, 1'b1, 32'd2);
    check("cyc2.opcode", {26'd0, opcode}, {26'd0, 6'b101011});
    check("wrap.cyc2.pc",  pc2, 32'h4);
    check("wrap.cyc2.pc4", if_id_pc42, 32'h4);

    // Three stalled cycles hold everything.
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_slot($sformatf("stall%0d", i), 32'h8, 32'hAC02_0008, 32'h8, 1'b1, 32'd2);
    end
    stall = 1'b0;
    step();
    check_slot("resume", 32'hC, 32'h2001_0001, 32'hC, 1'b1, 32'd3);

    // Branch with stall: redirect wins, slot squashed, target aligned.
    branch_taken = 1'b1; branch_target = 32'h0000_0043; stall = 1'b1;
    step();
    check_slot("branch", 32'h40, 32'h0, 32'h0, 1'b0, 32'd3);
    check("branch.opcode", {26'd0, opcode}, {26'd0, 6'b111111});
    branch_taken = 1'b0; stall = 1'b0;
    step();
    check_slot("target", 32'h44, 32'h3C01_1234, 32'h44, 1'b1, 32'd4);

    // Flush with stall: bubble inserted, PC held.
    flush = 1'b1; stall = 1'b1;
    step();
    check_slot("flush_stall", 32'h44, 32'h0, 32'h0, 1'b0, 32'd4);
    // Flush alone: bubble inserted, PC advances.
    stall = 1'b0;
    step();
    check_slot("flush", 32'h48, 32'h0, 32'h0, 1'b0, 32'd4);
    flush = 1'b0;
    step();
    check_slot("after_flush", 32'h4C, 32'h0800_0012, 32'h4C, 1'b1, 32'd5);

    // Reset during a branch request: nothing moves before the edge.
    rst_n = 1'b0; branch_taken = 1'b1; branch_target = 32'h0000_0200;
    #1;
    check("rst_pre_edge.pc", pc, 32'h4C);
    check("rst_pre_edge.count", fetch_count, 32'd5);
    step();
    check_slot("rst_branch", 32'h0, 32'h0, 32'h0, 1'b0, 32'd0);
    check("rst_branch.booting", {31'd0, booting}, 32'd1);
    rst_n = 1'b1; branch_taken = 1'b0;
    step();
    check_slot("rerun", 32'h4, 32'h8C02_0004, 32'h4, 1'b1, 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
